// File: rtl/uart_receiver_if.sv
// Read-side port bundle of the UART receiver: FIFO pop handshake, head byte and fill status.
interface uart_receiver_if;
    logic       read_enable;
    logic [5:0] buffer_full_threshold;
    logic [7:0] data_out;
    logic       buffer_empty;
    logic       buffer_full;
    logic [6:0] buffer_count;

    modport master (
        output read_enable, buffer_full_threshold,
        input  data_out, buffer_empty, buffer_full, buffer_count
    );

    modport slave (
        input  read_enable, buffer_full_threshold,
        output data_out, buffer_empty, buffer_full, buffer_count
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with four selectable bit rates feeding a 64-entry
// first-word-fall-through FIFO with a programmable almost-full flag.
module uart_receiver #(
    parameter int DIV_0 = 16,
    parameter int DIV_1 = 32,
    parameter int DIV_2 = 64,
    parameter int DIV_3 = 128
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           serial_in,
    input  logic [1:0]     baudrate_select,
    uart_receiver_if.slave rd,
    output logic           frame_error,
    output logic           overrun
);
    localparam int DMAX01 = (DIV_0 > DIV_1) ? DIV_0 : DIV_1;
    localparam int DMAX23 = (DIV_2 > DIV_3) ? DIV_2 : DIV_3;
    localparam int DMAX   = (DMAX01 > DMAX23) ? DMAX01 : DMAX23;
    localparam int CW     = $clog2(DMAX + 1);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [1:0]      sync;
    logic            rx_s;
    logic [CW-1:0]   cyc_cnt, cyc_n;
    logic [CW-1:0]   div_q, div_n, sel_div;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      shift, shift_n;
    logic            push, pop, fe, ov;

    logic [7:0]      mem [64];
    logic [5:0]      wr_ptr, rd_ptr;
    logic [6:0]      count;
    logic [7:0]      dout;

    assign rx_s = sync[1];

    always_comb begin
        case (baudrate_select)
            2'd0:    sel_div = CW'(DIV_0);
            2'd1:    sel_div = CW'(DIV_1);
            2'd2:    sel_div = CW'(DIV_2);
            default: sel_div = CW'(DIV_3);
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync    <= 2'b11;
            state   <= WAIT_IDLE;
            cyc_cnt <= '0;
            div_q   <= CW'(DIV_0);
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            sync    <= {sync[0], serial_in};
            state   <= state_n;
            cyc_cnt <= cyc_n;
            div_q   <= div_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
        end
    end

    // cyc_cnt counts cycles since the last sample point (or since t0), so the
    // first sample lands at D/2 and every later one a full D after it.
    always_comb begin
        state_n = state;
        cyc_n   = cyc_cnt + 1'b1;
        div_n   = div_q;
        bit_n   = bit_cnt;
        shift_n = shift;
        push    = 1'b0;
        fe      = 1'b0;
        ov      = 1'b0;
        case (state)
            WAIT_IDLE: begin
                cyc_n = CW'(1);
                if (rx_s) state_n = IDLE;
            end
            IDLE: begin
                cyc_n = CW'(1);
                bit_n = '0;
                if (!rx_s) begin
                    div_n   = sel_div;
                    state_n = START;
                end
            end
            START: begin
                if (cyc_cnt == (div_q >> 1)) begin
                    cyc_n   = CW'(1);
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cyc_cnt == div_q) begin
                    cyc_n   = CW'(1);
                    shift_n = {rx_s, shift[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cyc_cnt == div_q) begin
                    if (!rx_s) begin
                        fe      = 1'b1;
                        state_n = WAIT_IDLE;
                    end else if (count == 7'd64 && !rd.read_enable) begin
                        ov      = 1'b1;
                        state_n = IDLE;
                    end else begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
        if (reset) begin
            push = 1'b0;
            fe   = 1'b0;
            ov   = 1'b0;
        end
    end

    assign frame_error = fe;
    assign overrun     = ov;
    assign pop         = rd.read_enable && (count != 7'd0) && !reset;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= shift;
    end

    // dout mirrors the head entry; it only changes when the head itself changes,
    // so it keeps the last popped byte once the FIFO drains.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 6'd1;
            if (pop)  rd_ptr <= rd_ptr + 6'd1;
            case ({push, pop})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: count <= count;
            endcase
            if (pop && count > 7'd1)
                dout <= mem[rd_ptr + 6'd1];
            else if (push && (count == 7'd0 || (pop && count == 7'd1)))
                dout <= shift;
        end
    end

    assign rd.data_out     = dout;
    assign rd.buffer_empty = (count == 7'd0);
    assign rd.buffer_full  = (count >= {1'b0, rd.buffer_full_threshold});
    assign rd.buffer_count = count;
endmodule
